// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between CPU writeback
// and a buffered I/O injector, with a starvation guard that stalls the CPU once.
module regfile_write_arbiter #(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                       clock,
   input  logic                       ctrl_reset,
   input  logic                       wb_we,
   input  logic [4:0]                 wb_reg,
   input  logic [31:0]                wb_data,
   input  logic                       io_valid,
   output logic                       io_ready,
   input  logic [4:0]                 io_reg,
   input  logic [31:0]                io_data,
   output logic                       cpu_stall,
   output logic                       rf_we,
   output logic [4:0]                 rf_reg,
   output logic [31:0]                rf_data,
   output logic [$clog2(DEPTH):0]     io_count,
   output logic                       proto_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [0:0] NORMAL = 1'b0;
   localparam logic [0:0] STALL  = 1'b1;

   logic [36:0]   mem [DEPTH];
   logic [36:0]   head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic [0:0]    state, state_nxt;
   logic          push, pop, nonempty, blocked;

   assign nonempty  = count != '0;
   assign io_ready  = count < CW'(DEPTH);
   assign io_count  = count;
   assign push      = io_valid && io_ready;
   assign pop       = !wb_we && nonempty;
   assign blocked   = wb_we && nonempty;
   assign head      = mem[rd_ptr];
   assign cpu_stall = state == STALL;

   // The guard trips on the edge where the blocked count reaches MAX_WAIT.
   always_comb begin
      wait_nxt  = pop ? '0 : (blocked && wait_cnt != WW'(MAX_WAIT)) ? wait_cnt + 1'b1 : wait_cnt;
      state_nxt = pop ? NORMAL : (blocked && wait_nxt == WW'(MAX_WAIT)) ? STALL : state;
   end

   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= {io_reg, io_data};

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wait_cnt  <= '0;
         state     <= NORMAL;
         proto_err <= 1'b0;
         rf_we     <= 1'b0;
         rf_reg    <= '0;
         rf_data   <= '0;
      end else begin
         wr_ptr    <= wr_ptr + AW'(push);
         rd_ptr    <= rd_ptr + AW'(pop);
         count     <= count + CW'(push) - CW'(pop);
         wait_cnt  <= wait_nxt;
         state     <= state_nxt;
         proto_err <= proto_err | (wb_we && state == STALL);
         if (wb_we) begin
            rf_we   <= wb_reg != '0;
            rf_reg  <= wb_reg;
            rf_data <= wb_data;
         end else if (nonempty) begin
            rf_we   <= head[36:32] != '0;
            rf_reg  <= head[36:32];
            rf_data <= head[31:0];
         end else begin
            rf_we   <= 1'b0;
         end
      end
   end
endmodule
